// File: rtl/race_timer_pkg.sv
// race_timer_pkg
// Shared definitions for the race timer slice: the width of the elapsed-time
// values, their saturation ceiling, the race FSM state encodings and a
// saturating increment helper used by the tick counter.
package race_timer_pkg;

   localparam int TIME_W = 22;
   localparam logic [TIME_W-1:0] TIME_MAX = 22'h3FFFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUNNING  = 2'd1,
      FINISHED = 2'd2
   } state_t;

   // Increment that sticks at TIME_MAX instead of wrapping back to zero, so a
   // very long race never reports a deceptively small time.
   function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
      return (v == TIME_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/race_timer_if.sv
// race_timer_if
// Bundles the race control pulses and the result outputs of the race timer.
//   start            : race start pulse (countdown complete)
//   finish_p1/p2     : player crossed the finish line pulses
//   key_press_status : restart key acknowledged by the scoreboard (level)
//   time_p1/p2       : registered elapsed ticks per player
//   end_game_status  : high while the results are displayed
//   race_active      : high while the race is running
// Modports: master drives the control inputs (scoreboard / bench),
//           slave is the race timer itself.
interface race_timer_if;
   import race_timer_pkg::*;

   logic              start;
   logic              finish_p1;
   logic              finish_p2;
   logic              key_press_status;
   logic [TIME_W-1:0] time_p1;
   logic [TIME_W-1:0] time_p2;
   logic              end_game_status;
   logic              race_active;

   modport master (
      output start, finish_p1, finish_p2, key_press_status,
      input  time_p1, time_p2, end_game_status, race_active
   );

   modport slave (
      input  start, finish_p1, finish_p2, key_press_status,
      output time_p1, time_p2, end_game_status, race_active
   );

endinterface

// File: rtl/race_timer_tick_gen.sv
// tick_gen
// Prescaler that divides clk down to the race time base. It counts
// 0..CLK_DIV-1 while enabled and emits a one-cycle tick in the cycle the
// count sits at CLK_DIV-1, i.e. the cycle in which it wraps.
//   clk   : clock
//   reset : synchronous active-high reset
//   clr   : synchronous clear of the count (race start)
//   en    : count enable (race running)
//   tick  : one-cycle time-base pulse
// Parameter CLK_DIV: clk cycles per tick.
module tick_gen #(
   parameter int CLK_DIV = 65000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count;

   // The tick is taken straight from the count so the consumer sees it in the
   // same cycle the prescaler wraps; the count itself is the registered state.
   assign tick = en && (count == CNT_LAST);

   // Prescaler count: clear has priority over counting so a new race always
   // starts a full tick period away from its first tick.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en) begin
         if (count == CNT_LAST) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/race_timer.sv
// race_timer
// Two-player race timer. A start pulse launches the race, each player's
// finish pulse latches the current tick count into that player's time, and
// once both players are done the results are shown until the restart key is
// acknowledged.
//   clk   : clock
//   reset : synchronous active-high reset, overrides every other input
//   bus   : race_timer_if.slave (control pulses in, results out)
// Parameters:
//   CLK_DIV       : clk cycles per time tick
//   TIMEOUT_TICKS : race timeout in ticks (only with RACE_TIMER_TIMEOUT_EN)
// Build option: define RACE_TIMER_TIMEOUT_EN to force unfinished players to
// TIME_MAX once the race has run for TIMEOUT_TICKS ticks.
module race_timer
   import race_timer_pkg::*;
#(
   parameter int CLK_DIV       = 65000,
   parameter int TIMEOUT_TICKS = 30000
) (
   input logic       clk,
   input logic       reset,
   race_timer_if.slave bus
);

   // Reject parameter values that would make the time base or the timeout
   // meaningless before anything is built.
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("race_timer: CLK_DIV must be at least 1");
   end
   if ((TIMEOUT_TICKS < 1) || (TIMEOUT_TICKS > 32'h3FFFFF)) begin : g_bad_timeout
      $error("race_timer: TIMEOUT_TICKS must be within 1..22'h3FFFFF");
   end

   state_t            state;
   logic [TIME_W-1:0] tick_count;
   logic [TIME_W-1:0] time_p1;
   logic [TIME_W-1:0] time_p2;
   logic              done_p1;
   logic              done_p2;
   logic              end_game_status;
   logic              race_active;

   logic tick;
   logic prescale_clr;
   logic prescale_en;

   // The prescaler restarts on the same edge that launches the race and only
   // runs while the race is live, so idle and result phases freeze the time.
   assign prescale_clr = (state == IDLE) && bus.start;
   assign prescale_en  = (state == RUNNING);

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clr   (prescale_clr),
      .en    (prescale_en),
      .tick  (tick)
   );

`ifdef RACE_TIMER_TIMEOUT_EN
   logic timeout_hit;

   // Once the race has lasted the full timeout, anyone still on the track is
   // treated as having finished with the worst possible time.
   assign timeout_hit = (tick_count >= TIME_W'(TIMEOUT_TICKS));
`endif

   // Race FSM with all outputs registered. Done flags are checked from their
   // registered value, so FINISHED is entered one edge after the second
   // player's time is latched; race_active and end_game_status are updated
   // on the same edges as the state so they always mirror it exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         tick_count      <= '0;
         time_p1         <= '0;
         time_p2         <= '0;
         done_p1         <= 1'b0;
         done_p2         <= 1'b0;
         end_game_status <= 1'b0;
         race_active     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state           <= RUNNING;
                  tick_count      <= '0;
                  time_p1         <= '0;
                  time_p2         <= '0;
                  done_p1         <= 1'b0;
                  done_p2         <= 1'b0;
                  race_active     <= 1'b1;
                  end_game_status <= 1'b0;
               end
            end

            RUNNING: begin
               if (tick) begin
                  tick_count <= sat_inc(tick_count);
               end

               if (bus.finish_p1 && !done_p1) begin
                  time_p1 <= tick_count;
                  done_p1 <= 1'b1;
               end
`ifdef RACE_TIMER_TIMEOUT_EN
               else if (timeout_hit && !done_p1) begin
                  time_p1 <= TIME_MAX;
                  done_p1 <= 1'b1;
               end
`endif

               if (bus.finish_p2 && !done_p2) begin
                  time_p2 <= tick_count;
                  done_p2 <= 1'b1;
               end
`ifdef RACE_TIMER_TIMEOUT_EN
               else if (timeout_hit && !done_p2) begin
                  time_p2 <= TIME_MAX;
                  done_p2 <= 1'b1;
               end
`endif

               if (done_p1 && done_p2) begin
                  state           <= FINISHED;
                  race_active     <= 1'b0;
                  end_game_status <= 1'b1;
               end
            end

            FINISHED: begin
               if (bus.key_press_status) begin
                  state           <= IDLE;
                  end_game_status <= 1'b0;
               end
            end

            default: begin
               state           <= IDLE;
               race_active     <= 1'b0;
               end_game_status <= 1'b0;
            end
         endcase
      end
   end

   assign bus.time_p1         = time_p1;
   assign bus.time_p2         = time_p2;
   assign bus.end_game_status = end_game_status;
   assign bus.race_active     = race_active;

endmodule

// File: tb/tb_race_timer.sv
// tb_race_timer
// Directed bench for race_timer with CLK_DIV=4 and TIMEOUT_TICKS=20. Inputs
// change on the falling edge and outputs are sampled on the falling edge, so
// one bench step spans exactly one rising edge. After a start step, N ticks
// have elapsed once 4*N further steps have passed. Build with
// RACE_TIMER_TIMEOUT_EN defined to exercise the timeout path.
module tb_race_timer;
   import race_timer_pkg::*;

   localparam int CLK_DIV       = 4;
   localparam int TIMEOUT_TICKS = 20;
   localparam int NUM_VECS      = 20;

   typedef struct {
      int                idle;
      logic              start;
      logic              f1;
      logic              f2;
      logic              key;
      logic [TIME_W-1:0] t1;
      logic [TIME_W-1:0] t2;
      logic              eg;
      logic              ra;
   } vec_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   vec_t vecs [NUM_VECS];

   race_timer_if bus ();

   race_timer #(
      .CLK_DIV       (CLK_DIV),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Idle for the given number of steps, then apply one step with the given
   // pulses and release them again.
   task automatic applyStimulus(input int idle, input logic s, input logic f1,
                                input logic f2, input logic key);
      bus.start            = 1'b0;
      bus.finish_p1        = 1'b0;
      bus.finish_p2        = 1'b0;
      bus.key_press_status = 1'b0;
      for (int i = 0; i < idle; i++) @(negedge clk);
      bus.start            = s;
      bus.finish_p1        = f1;
      bus.finish_p2        = f2;
      bus.key_press_status = key;
      @(negedge clk);
      bus.start            = 1'b0;
      bus.finish_p1        = 1'b0;
      bus.finish_p2        = 1'b0;
      bus.key_press_status = 1'b0;
   endtask

   // Compare all four outputs against the expected values.
   task automatic checkOutput(input string name, input logic [TIME_W-1:0] t1,
                              input logic [TIME_W-1:0] t2, input logic eg,
                              input logic ra);
      checks++;
      if (bus.time_p1 !== t1) begin
         errors++;
         $display("[TB] FAIL %s time_p1 got %0h want %0h", name, bus.time_p1, t1);
      end
      checks++;
      if (bus.time_p2 !== t2) begin
         errors++;
         $display("[TB] FAIL %s time_p2 got %0h want %0h", name, bus.time_p2, t2);
      end
      checks++;
      if (bus.end_game_status !== eg) begin
         errors++;
         $display("[TB] FAIL %s end_game_status got %b want %b", name, bus.end_game_status, eg);
      end
      checks++;
      if (bus.race_active !== ra) begin
         errors++;
         $display("[TB] FAIL %s race_active got %b want %b", name, bus.race_active, ra);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset                = 1'b1;
      bus.start            = 1'b0;
      bus.finish_p1        = 1'b0;
      bus.finish_p2        = 1'b0;
      bus.key_press_status = 1'b0;

      // idle, start, f1, f2, key, exp time_p1, exp time_p2, exp eg, exp ra
      // Basic race: p1 at tick 10, p2 at tick 15, then restart handshake.
      vecs[0]  = '{2,  0, 1, 0, 0, 22'd0,  22'd0,  1'b0, 1'b0};
      vecs[1]  = '{0,  1, 0, 0, 0, 22'd0,  22'd0,  1'b0, 1'b1};
      vecs[2]  = '{40, 0, 1, 0, 0, 22'd10, 22'd0,  1'b0, 1'b1};
      vecs[3]  = '{19, 0, 0, 1, 0, 22'd10, 22'd15, 1'b0, 1'b1};
      vecs[4]  = '{0,  0, 0, 0, 0, 22'd10, 22'd15, 1'b1, 1'b0};
      vecs[5]  = '{0,  1, 0, 0, 0, 22'd10, 22'd15, 1'b1, 1'b0};
      vecs[6]  = '{0,  0, 1, 0, 0, 22'd10, 22'd15, 1'b1, 1'b0};
      vecs[7]  = '{0,  0, 0, 0, 1, 22'd10, 22'd15, 1'b0, 1'b0};
      vecs[8]  = '{3,  0, 0, 0, 0, 22'd10, 22'd15, 1'b0, 1'b0};
      // New start clears times; simultaneous finish at tick 7.
      vecs[9]  = '{0,  1, 0, 0, 0, 22'd0,  22'd0,  1'b0, 1'b1};
      vecs[10] = '{28, 0, 1, 1, 0, 22'd7,  22'd7,  1'b0, 1'b1};
      vecs[11] = '{0,  0, 0, 0, 0, 22'd7,  22'd7,  1'b1, 1'b0};
      vecs[12] = '{0,  0, 0, 0, 1, 22'd7,  22'd7,  1'b0, 1'b0};
      // Ignore rules: p1 at tick 5, repeat at tick 12, start mid-race,
      // then p2 at tick 15 proves the race was not restarted.
      vecs[13] = '{0,  1, 0, 0, 0, 22'd0,  22'd0,  1'b0, 1'b1};
      vecs[14] = '{20, 0, 1, 0, 0, 22'd5,  22'd0,  1'b0, 1'b1};
      vecs[15] = '{27, 0, 1, 0, 0, 22'd5,  22'd0,  1'b0, 1'b1};
      vecs[16] = '{3,  1, 0, 0, 0, 22'd5,  22'd0,  1'b0, 1'b1};
      vecs[17] = '{7,  0, 0, 1, 0, 22'd5,  22'd15, 1'b0, 1'b1};
      vecs[18] = '{0,  0, 0, 0, 0, 22'd5,  22'd15, 1'b1, 1'b0};
      vecs[19] = '{0,  0, 0, 0, 1, 22'd5,  22'd15, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      checkOutput("reset", 22'd0, 22'd0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].idle, vecs[i].start, vecs[i].f1, vecs[i].f2, vecs[i].key);
         checkOutput($sformatf("vec%0d", i), vecs[i].t1, vecs[i].t2, vecs[i].eg, vecs[i].ra);
      end

      // Reset mid-race at tick 9 with p1 already done, held against a
      // simultaneous finish pulse.
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_start", 22'd0, 22'd0, 1'b0, 1'b1);
      applyStimulus(20, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_p1", 22'd5, 22'd0, 1'b0, 1'b1);
      applyStimulus(15, 1'b0, 1'b0, 1'b0, 1'b0);
      reset         = 1'b1;
      bus.finish_p2 = 1'b1;
      @(negedge clk);
      reset         = 1'b0;
      bus.finish_p2 = 1'b0;
      checkOutput("rst_mid", 22'd0, 22'd0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_idle", 22'd0, 22'd0, 1'b0, 1'b0);
      // Fresh race counts from zero and p1's done flag is clear again.
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_restart", 22'd0, 22'd0, 1'b0, 1'b1);
      applyStimulus(8, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("rst_p2", 22'd0, 22'd2, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_p1b", 22'd2, 22'd2, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_done", 22'd2, 22'd2, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_key", 22'd2, 22'd2, 1'b0, 1'b0);

      // Timeout: p1 at tick 4, p2 never finishes; run well past tick 20.
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("to_start", 22'd0, 22'd0, 1'b0, 1'b1);
      applyStimulus(16, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("to_p1", 22'd4, 22'd0, 1'b0, 1'b1);
      applyStimulus(70, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RACE_TIMER_TIMEOUT_EN
      checkOutput("to_expired", 22'd4, TIME_MAX, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("to_key", 22'd4, TIME_MAX, 1'b0, 1'b0);
`else
      checkOutput("to_running", 22'd4, 22'd0, 1'b0, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("to_reset", 22'd0, 22'd0, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/race_timer.md
RACE_TIMER -- requirements
Module: race_timer

Interface
REQ-001 The block SHALL have a parameter CLK_DIV, default 65000, giving clk cycles per time tick (1 ms at 65 MHz).
REQ-002 The block SHALL have a parameter TIMEOUT_TICKS, default 30000, giving the race timeout in ticks; it is used only when RACE_TIMER_TIMEOUT_EN is defined.
REQ-003 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle race start pulse (countdown complete).
REQ-006 finish_p1  input  1  single-cycle pulse: player 1 crossed the line.
REQ-007 finish_p2  input  1  single-cycle pulse: player 2 crossed the line.
REQ-008 key_press_status  input  1  level from the scoreboard: restart key acknowledged.
REQ-009 time_p1  output  22  player 1 elapsed ticks, registered.
REQ-010 time_p2  output  22  player 2 elapsed ticks, registered.
REQ-011 end_game_status  output  1  high while the results are displayed.
REQ-012 race_active  output  1  high while the race is in RUNNING.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUNNING, FINISHED.
REQ-014 In IDLE, a start pulse SHALL move the FSM to RUNNING on the next edge and SHALL, on that same edge, clear time_p1, time_p2, the tick counter, the prescaler and both done flags.
REQ-015 The prescaler SHALL count 0..CLK_DIV-1 in RUNNING only and SHALL emit a one-cycle tick on wrap; the tick counter SHALL increment on each tick and saturate at 22'h3FFFFF.
REQ-016 In RUNNING, finish_pX with its done flag clear SHALL load time_pX with the current tick count and set done_pX on the next edge, giving 1-cycle latency.
REQ-017 Repeat finish_pX pulses after done_pX is set SHALL be ignored, and time_pX SHALL hold its value.
REQ-018 finish_p1 and finish_p2 in the same cycle SHALL load equal values into both outputs.
REQ-019 When both done flags are set, the FSM SHALL enter FINISHED on the following edge, and end_game_status SHALL be high from that edge on.
REQ-020 In FINISHED, key_press_status=1 SHALL return the FSM to IDLE and drop end_game_status on the next edge; time_p1 and time_p2 SHALL hold until the next start.
REQ-021 start SHALL be ignored in RUNNING and FINISHED, and finish pulses SHALL be ignored in IDLE and FINISHED.
REQ-022 race_active SHALL equal (state == RUNNING), and end_game_status SHALL equal (state == FINISHED); both SHALL be registered.

Reset
REQ-023 reset SHALL force IDLE, time_p1=0, time_p2=0, end_game_status=0, race_active=0, clear both done flags and zero the prescaler and tick counter, in any state including mid-race; reset SHALL have priority over all inputs.

Configuration
REQ-024 With RACE_TIMER_TIMEOUT_EN defined, when the tick count in RUNNING reaches TIMEOUT_TICKS, every player whose done flag is clear SHALL be loaded with 22'h3FFFFF and marked done, and REQ-019 SHALL then apply.
REQ-025 Without RACE_TIMER_TIMEOUT_EN, no timeout logic SHALL exist, and RUNNING SHALL be left only via both finishes or reset.

Structure
REQ-026 The shared package/header SHALL hold TIME_W=22, TIME_MAX=22'h3FFFFF and the state encodings IDLE=2'd0, RUNNING=2'd1, FINISHED=2'd2.
REQ-027 The prescaler SHALL be a separate sub-module tick_gen (inputs clk, reset, clr, en; output tick); all other logic SHALL reside in race_timer.

Verification (bench CLK_DIV=4, TIMEOUT_TICKS=20)
REQ-028 Basic race: start, finish_p1 after 10 ticks, finish_p2 after 15 ticks -> time_p1=10, time_p2=15; end_game_status rises 1 cycle after time_p2 loads.
REQ-029 Simultaneous finish: both pulses in the same cycle at tick 7 -> time_p1=time_p2=7; FINISHED on the next edge.
REQ-030 Ignore rules: finish_p1 in IDLE, repeated finish_p1 at tick 12 after a load at tick 5, and start mid-race -> time_p1 stays 5, and the race is not restarted.
REQ-031 Restart handshake: in FINISHED, key_press_status=1 -> IDLE, end_game_status=0 next edge, times held; a new start clears both times to 0.
REQ-032 Reset mid-race at tick 9 with done_p1 set -> all outputs 0, IDLE; a later start begins again from 0.
REQ-033 With RACE_TIMER_TIMEOUT_EN: finish_p1 at tick 4 and no finish_p2 -> at tick 20, time_p2=22'h3FFFFF, time_p1=4, end_game_status=1; without the macro the FSM stays in RUNNING.
